// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer and its counter.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ARITH   = 2'b01,
        MODE_ROTATE  = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_FIN   = 2'b11
    } state_t;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_SR   = 2'b01;
    localparam logic [1:0] SEL_SL   = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    // The unused encoding 11 behaves as a logical shift.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   decode_mode = MODE_ARITH;
            2'b10:   decode_mode = MODE_ROTATE;
            default: decode_mode = MODE_LOGICAL;
        endcase
    endfunction

endpackage

// File: rtl/shift_count_ctr.sv
// Down counter for the shift phase; flags the last shift before it happens.
module shift_count_ctr #(
    parameter int CW = 6
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          next_zero
);

    logic [CW-1:0] cnt;

    // Load takes priority; decrement is only requested while shifting, when cnt >= 1.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - CW'(1);
    end

    assign next_zero = (cnt == CW'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Sequences a chain of 4-bit universal shift slices as one W-bit shifter.
// Data buses are numbered [0:W-1] so bit 0 is the MSB, matching the chain.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter  int NSLICE = 9,
    parameter  int CW     = 6,
    localparam int W      = 4 * NSLICE
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ,
    input  logic [0:W-1]  DIN,
    input  logic          DIR,
    input  logic [1:0]    MODE,
    input  logic [CW-1:0] COUNT,
    input  logic [0:W-1]  CHAIN_Q,
    output logic [1:0]    CHAIN_SEL,
    output logic [0:W-1]  CHAIN_D,
    output logic          CHAIN_FILL_L,
    output logic          CHAIN_FILL_R,
    output logic          BUSY,
    output logic          DONE,
    output logic          OVF
);

    state_t        state;
    logic [1:0]    chain_sel;
    logic [0:W-1]  chain_d;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [0:W-1]  din_q;
    logic          dir_q;
    mode_t         mode_q;
    logic [CW-1:0] count_q;
    logic          next_zero;
    logic          fill_l;
    logic          fill_r;

    shift_count_ctr #(.CW(CW)) u_ctr (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (state == ST_LOAD),
        .dec       (state == ST_SHIFT),
        .load_val  (count_q),
        .next_zero (next_zero)
    );

    // Sequencer FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            chain_sel <= SEL_HOLD;
            chain_d   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            din_q     <= '0;
            dir_q     <= 1'b0;
            mode_q    <= MODE_LOGICAL;
            count_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ) begin
                        din_q     <= DIN;
                        dir_q     <= DIR;
                        mode_q    <= decode_mode(MODE);
                        count_q   <= COUNT;
                        ovf       <= 1'b0;
                        state     <= ST_LOAD;
                        chain_sel <= SEL_LOAD;
                        chain_d   <= DIN;
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    chain_d <= '0;
                    if (count_q == '0) begin
                        state     <= ST_FIN;
                        chain_sel <= SEL_HOLD;
                        done      <= 1'b1;
                    end else begin
                        state     <= ST_SHIFT;
                        chain_sel <= dir_q ? SEL_SL : SEL_SR;
                    end
                end
                ST_SHIFT: begin
                    // Bit about to leave differs from the new sign bit.
                    if (mode_q == MODE_ARITH && dir_q && (CHAIN_Q[0] != CHAIN_Q[1]))
                        ovf <= 1'b1;
                    if (next_zero) begin
                        state     <= ST_FIN;
                        chain_sel <= SEL_HOLD;
                        done      <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    chain_sel <= SEL_HOLD;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // End fill bits; only meaningful while shifting, forced low otherwise.
    always_comb begin
        fill_l = 1'b0;
        fill_r = 1'b0;
        if (state == ST_SHIFT) begin
            if (!dir_q) begin
                case (mode_q)
                    MODE_ARITH:  fill_l = CHAIN_Q[0];
                    MODE_ROTATE: fill_l = CHAIN_Q[W-1];
                    default:     fill_l = 1'b0;
                endcase
            end else if (mode_q == MODE_ROTATE) begin
                fill_r = CHAIN_Q[0];
            end
        end
    end

    assign CHAIN_SEL    = chain_sel;
    assign CHAIN_D      = chain_d;
    assign CHAIN_FILL_L = fill_l;
    assign CHAIN_FILL_R = fill_r;
    assign BUSY         = busy;
    assign DONE         = done;
    assign OVF          = ovf;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: shift_sequencer driving a behavioural 36-bit slice chain.
module tb_shift_sequencer;

    localparam int NSLICE = 9;
    localparam int CW     = 6;
    localparam int W      = 4 * NSLICE;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic [0:W-1]  din;
    logic          dir;
    logic [1:0]    mode;
    logic [CW-1:0] count;
    logic [0:W-1]  chain_q;
    logic [1:0]    chain_sel;
    logic [0:W-1]  chain_d;
    logic          fill_l;
    logic          fill_r;
    logic          busy;
    logic          done;
    logic          ovf;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    shift_sequencer #(.NSLICE(NSLICE), .CW(CW)) dut (
        .CLK          (clk),
        .RESET        (reset),
        .REQ          (req),
        .DIN          (din),
        .DIR          (dir),
        .MODE         (mode),
        .COUNT        (count),
        .CHAIN_Q      (chain_q),
        .CHAIN_SEL    (chain_sel),
        .CHAIN_D      (chain_d),
        .CHAIN_FILL_L (fill_l),
        .CHAIN_FILL_R (fill_r),
        .BUSY         (busy),
        .DONE         (done),
        .OVF          (ovf)
    );

    always #5 clk = ~clk;

    // Slice chain: bit 0 is the MSB; right shift moves toward bit W-1.
    always @(posedge clk or posedge reset) begin
        if (reset)
            chain_q <= '0;
        else case (chain_sel)
            2'b00: chain_q <= chain_d;
            2'b01: chain_q <= {fill_l, chain_q[0:W-2]};
            2'b10: chain_q <= {chain_q[1:W-1], fill_r};
            default: chain_q <= chain_q;
        endcase
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for DONE; checks LOAD-cycle outputs and latency.
    task automatic run_req(input string tag, input logic [0:W-1] d, input logic dr,
                           input logic [1:0] md, input logic [CW-1:0] cnt,
                           input logic [0:W-1] exp_q, input logic exp_ovf);
        int lat;
        @(negedge clk);
        req = 1'b1; din = d; dir = dr; mode = md; count = cnt;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; din = '0;
        lat = 1;
        check_val({tag, "_load_sel"}, 64'(chain_sel), 64'(2'b00));
        check_val({tag, "_load_d"}, 64'(chain_d), 64'(d));
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_done_seen"}, 64'(done), 64'(1'b1));
        check_val({tag, "_latency"}, 64'(lat), 64'(int'(cnt) + 2));
        check_val({tag, "_q"}, 64'(chain_q), 64'(exp_q));
        check_val({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        check_val({tag, "_d_zero"}, 64'(chain_d), 64'(0));
        @(negedge clk);
        check_val({tag, "_idle"}, 64'(busy), 64'(1'b0));
    endtask

    initial begin
        int base;
        reset = 1'b1; req = 1'b0; din = '0; dir = 1'b0; mode = 2'b00; count = '0;
        #2;
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_sel", 64'(chain_sel), 64'(2'b11));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_ovf", 64'(ovf), 64'(0));
        check_val("rst_d", 64'(chain_d), 64'(0));
        check_val("rst_fills", 64'({fill_l, fill_r}), 64'(0));
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        run_req("lsr4",  36'h8_0000_00F0, 1'b0, 2'b00, 6'd4, 36'h0_8000_000F, 1'b0);
        run_req("asr4",  36'h8_0000_00F0, 1'b0, 2'b01, 6'd4, 36'hF_8000_000F, 1'b0);
        run_req("m11",   36'h8_0000_00F0, 1'b0, 2'b11, 6'd4, 36'h0_8000_000F, 1'b0);
        run_req("rol8",  36'h1_2345_6789, 1'b1, 2'b10, 6'd8, 36'h3_4567_8912, 1'b0);
        run_req("ror4",  36'h1_2345_6789, 1'b0, 2'b10, 6'd4, 36'h9_1234_5678, 1'b0);
        run_req("asl1",  36'h4_0000_0000, 1'b1, 2'b01, 6'd1, 36'h8_0000_0000, 1'b1);
        @(negedge clk);
        check_val("ovf_held", 64'(ovf), 64'(1'b1));
        run_req("asl_ok", 36'h0_0000_0001, 1'b1, 2'b01, 6'd1, 36'h0_0000_0002, 1'b0);
        run_req("lsl3",  36'h0_0000_000F, 1'b1, 2'b00, 6'd3, 36'h0_0000_0078, 1'b0);
        run_req("cnt0",  36'hA_5A5A_5A5A, 1'b0, 2'b00, 6'd0, 36'hA_5A5A_5A5A, 1'b0);
        run_req("lsr40", 36'hF_FFFF_FFFF, 1'b0, 2'b00, 6'd40, 36'h0, 1'b0);
        run_req("asr40", 36'h8_0000_0000, 1'b0, 2'b01, 6'd40, 36'hF_FFFF_FFFF, 1'b0);
        run_req("rol38", 36'h1_2345_6789, 1'b1, 2'b10, 6'd38, 36'h4_8D15_9E24, 1'b0);
        run_req("max63", 36'h8_0000_0000, 1'b0, 2'b01, 6'd63, 36'hF_FFFF_FFFF, 1'b0);

        // REQ while busy (SHIFT and FIN) must be ignored.
        base = done_cnt;
        @(negedge clk);
        req = 1'b1; din = 36'h0_0000_0001; dir = 1'b1; mode = 2'b00; count = 6'd10;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        req = 1'b1; din = 36'hF_FFFF_FFFF; count = 6'd1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 30 && !done; i++) @(negedge clk);
        check_val("busy_done_seen", 64'(done), 64'(1'b1));
        check_val("busy_q", 64'(chain_q), 64'(36'h0_0000_0400));
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_val("fin_req_ignored", 64'(busy), 64'(1'b0));
        repeat (15) @(negedge clk);
        check_val("busy_one_done", 64'(done_cnt - base), 64'(1));
        check_val("busy_q_hold", 64'(chain_q), 64'(36'h0_0000_0400));

        // Reset in the middle of a long shift.
        @(negedge clk);
        req = 1'b1; din = 36'h1_2345_6789; dir = 1'b0; mode = 2'b00; count = 6'd20;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        check_val("pre_rst_busy", 64'(busy), 64'(1'b1));
        base = done_cnt;
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", 64'(busy), 64'(0));
        check_val("mid_rst_sel", 64'(chain_sel), 64'(2'b11));
        check_val("mid_rst_q", 64'(chain_q), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check_val("mid_rst_no_done", 64'(done_cnt - base), 64'(0));
        run_req("post_rst", 36'h0_0000_0001, 1'b1, 2'b00, 6'd1, 36'h0_0000_0002, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
